// File: rtl/core_seq_pkg.sv
// Shared types, instruction-word bit map and geometry for the convolution-layer sequencer.
package core_seq_pkg;

  localparam int unsigned Row     = 8;
  localparam int unsigned Col     = 8;
  localparam int unsigned LenKij  = 9;
  localparam int unsigned Kw      = 3;
  localparam int unsigned LenNij  = 36;
  localparam int unsigned Iw      = 6;
  localparam int unsigned LenOnij = 16;
  localparam int unsigned Ow      = 4;
  localparam int unsigned AddrW   = 11;

  localparam logic [AddrW-1:0] WBase = 11'd64;
  localparam logic [AddrW-1:0] ABase = 11'd0;

  localparam int unsigned InstLoad    = 0;
  localparam int unsigned InstExec    = 1;
  localparam int unsigned InstL0Wr    = 2;
  localparam int unsigned InstL0Rd    = 3;
  localparam int unsigned InstOfifoRd = 6;
  localparam int unsigned InstXmemA   = 7;
  localparam int unsigned InstXmemWen = 18;
  localparam int unsigned InstXmemCen = 19;
  localparam int unsigned InstPmemA   = 20;
  localparam int unsigned InstPmemWen = 31;
  localparam int unsigned InstPmemCen = 32;
  localparam int unsigned InstAcc     = 33;
  localparam int unsigned InstFmemA   = 34;
  localparam int unsigned InstFmemWen = 45;
  localparam int unsigned InstFmemCen = 46;
  localparam int unsigned InstDbi     = 47;

  // Every SRAM deselected and read-only, no datapath strobes.
  localparam logic [47:0] IdleInst = 48'h6001_800C_0000;

  typedef enum logic [2:0] {
    StIdle, StWRd, StWLd, StARd, StAEx, StDrain, StAcc, StFin
  } state_e;

  // Input-pixel index seen by output pixel (o_row, o_col) under kernel tap (k_row, k_col).
  function automatic logic [AddrW-1:0] nij_addr(input logic [1:0] o_row, input logic [1:0] o_col,
                                                input logic [1:0] k_row, input logic [1:0] k_col);
    logic [AddrW-1:0] r;
    logic [AddrW-1:0] cidx;
    r    = AddrW'(o_row) + AddrW'(k_row);
    cidx = AddrW'(o_col) + AddrW'(k_col);
    return r * AddrW'(Iw) + cidx;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Host-side handshake plus the core instruction bus driven by the layer sequencer.
interface core_sequencer_if;
  logic        start;
  logic        dbi_cfg;
  logic        ofifo_valid;
  logic [47:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;

  modport master (
    output start, dbi_cfg, ofifo_valid,
    input  inst, busy, done, kij_idx
  );

  modport slave (
    input  start, dbi_cfg, ofifo_valid,
    output inst, busy, done, kij_idx
  );
endinterface

// File: rtl/seq_counter.sv
// Loadable up-counter; tc_o flags that the count has reached last_i. Load wins over increment.
module seq_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [Width-1:0] last_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);
  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == last_i);
endmodule

// File: rtl/core_sequencer.sv
// Sequences one convolution layer for core; outputs are the registered decode of the current state,
// so no extra transition cycles: a layer with ofifo_valid held high is busy for exactly 1320 cycles.
module core_sequencer
  import core_seq_pkg::*;
(
  input logic             clk,
  input logic             reset,
  core_sequencer_if.slave bus
);
  localparam logic [5:0] RowT    = 6'(Row);
  localparam logic [5:0] LenNijT = 6'(LenNij);
  localparam logic [3:0] KijLast = 4'(LenKij - 1);
  localparam logic [3:0] KijN    = 4'(LenKij);
  localparam logic [3:0] CLast   = 4'(LenKij + 1);
  localparam logic [3:0] OLast   = 4'(LenOnij - 1);
  localparam logic [1:0] KwLast  = 2'(Kw - 1);
  localparam logic [1:0] OwLast  = 2'(Ow - 1);

  state_e      state_q;
  logic [47:0] inst_q, inst_d;
  logic        busy_q, done_q;
  logic [3:0]  kij_idx_q;

  logic [5:0] t, t_last;
  logic       t_inc, t_load, t_tc;
  logic [3:0] kij, o, c;
  logic       kij_tc, o_tc, c_tc, c_load;
  logic       idle, in_acc, drain_step;
  logic [1:0] o_row_q, o_col_q, k_row_q, k_col_q;
  logic [AddrW-1:0] xmem_base;

  assign idle       = (state_q == StIdle);
  assign in_acc     = (state_q == StAcc);
  assign drain_step = (state_q == StDrain) && bus.ofifo_valid;
  assign t_load     = idle || (t_inc && t_tc);
  assign c_load     = !in_acc || c_tc;

  always_comb begin
    t_last = LenNijT - 6'd1;
    t_inc  = 1'b0;
    unique case (state_q)
      StWRd, StWLd: begin t_last = RowT;    t_inc = 1'b1; end
      StARd:        begin t_last = LenNijT; t_inc = 1'b1; end
      StAEx:        t_inc = 1'b1;
      StDrain:      t_inc = bus.ofifo_valid;
      default:      ;
    endcase
  end

  seq_counter #(.Width(6)) u_t_cnt (
    .clk_i(clk), .reset_i(reset), .load_i(t_load), .load_val_i(6'd0),
    .inc_i(t_inc), .last_i(t_last), .count_o(t), .tc_o(t_tc)
  );

  seq_counter #(.Width(4)) u_kij_cnt (
    .clk_i(clk), .reset_i(reset), .load_i(idle), .load_val_i(4'd0),
    .inc_i(drain_step && t_tc && !kij_tc), .last_i(KijLast), .count_o(kij), .tc_o(kij_tc)
  );

  seq_counter #(.Width(4)) u_o_cnt (
    .clk_i(clk), .reset_i(reset), .load_i(idle), .load_val_i(4'd0),
    .inc_i(in_acc && c_tc && !o_tc), .last_i(OLast), .count_o(o), .tc_o(o_tc)
  );

  seq_counter #(.Width(4)) u_c_cnt (
    .clk_i(clk), .reset_i(reset), .load_i(c_load), .load_val_i(4'd0),
    .inc_i(1'b1), .last_i(CLast), .count_o(c), .tc_o(c_tc)
  );

  // Row/column split of o and c, so the pixel address needs no divider.
  always_ff @(posedge clk) begin
    if (reset || idle) begin
      o_row_q <= '0;
      o_col_q <= '0;
    end else if (in_acc && c_tc) begin
      if (o_col_q == OwLast) begin
        o_col_q <= '0;
        o_row_q <= o_row_q + 2'd1;
      end else begin
        o_col_q <= o_col_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || c_load) begin
      k_row_q <= '0;
      k_col_q <= '0;
    end else if (k_col_q == KwLast) begin
      k_col_q <= '0;
      k_row_q <= k_row_q + 2'd1;
    end else begin
      k_col_q <= k_col_q + 2'd1;
    end
  end

  assign xmem_base = (state_q == StWRd) ? WBase + AddrW'(kij) * AddrW'(Row) : ABase;

  always_comb begin
    inst_d          = IdleInst;
    inst_d[InstDbi] = bus.dbi_cfg;
    unique case (state_q)
      StWRd, StARd: begin
        if (t < t_last) begin
          inst_d[InstXmemCen]        = 1'b0;
          inst_d[InstXmemA +: AddrW] = xmem_base + AddrW'(t);
        end
        inst_d[InstL0Wr] = (t != 6'd0);
      end
      StWLd: begin
        inst_d[InstL0Rd] = (t < RowT);
        inst_d[InstLoad] = (t < RowT);
      end
      StAEx: begin
        inst_d[InstL0Rd] = 1'b1;
        inst_d[InstExec] = 1'b1;
      end
      StDrain: begin
        if (bus.ofifo_valid && (t < LenNijT)) begin
          inst_d[InstOfifoRd]        = 1'b1;
          inst_d[InstPmemCen]        = 1'b0;
          inst_d[InstPmemWen]        = 1'b0;
          inst_d[InstPmemA +: AddrW] = AddrW'(kij) * AddrW'(LenNij) + AddrW'(t);
        end
      end
      StAcc: begin
        if (c < KijN) begin
          inst_d[InstPmemCen]        = 1'b0;
          inst_d[InstPmemA +: AddrW] = AddrW'(c) * AddrW'(LenNij)
                                       + nij_addr(o_row_q, o_col_q, k_row_q, k_col_q);
        end
        inst_d[InstAcc] = (c != 4'd0) && (c <= KijN);
        if (c == CLast) begin
          inst_d[InstFmemCen]        = 1'b0;
          inst_d[InstFmemWen]        = 1'b0;
          inst_d[InstFmemA +: AddrW] = AddrW'(o);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      inst_q    <= IdleInst;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      kij_idx_q <= '0;
    end else begin
      inst_q    <= inst_d;
      busy_q    <= !idle;
      done_q    <= (state_q == StFin);
      kij_idx_q <= kij;
      unique case (state_q)
        StIdle:  if (bus.start) state_q <= StWRd;
        StWRd:   if (t_tc) state_q <= StWLd;
        StWLd:   if (t_tc) state_q <= StARd;
        StARd:   if (t_tc) state_q <= StAEx;
        StAEx:   if (t_tc) state_q <= StDrain;
        StDrain: if (drain_step && t_tc) state_q <= kij_tc ? StAcc : StWRd;
        StAcc:   if (c_tc && o_tc) state_q <= StFin;
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.inst    = inst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.kij_idx = kij_idx_q;
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Generates the 48-bit `inst` word that drives `core` for one full convolution layer.
- Per kernel position (kij) it sequences:
  - weight fetch and kernel load;
  - activation fetch and execute;
  - OFIFO drain into the psum SRAM.
- After all kij it runs the output-stationary accumulation pass: it reads psums per output pixel (onij), accumulates them through the SFP, and writes the final SRAM.
- Sits between the testbench/host controller and `core`; it is the only driver of `core.inst`.

Parameters:
- row, 8, PE rows (weight words per kij).
- col, 8, PE columns.
- len_kij, 9, kernel positions (KW*KW).
- KW, 3, kernel width.
- len_nij, 36, input pixels (IW*IW).
- IW, 6, input width.
- len_onij, 16, output pixels (OW*OW).
- OW, 4, output width (IW-KW+1).
- W_BASE, 11'd64, xmem address of kij0 weight word 0.
- A_BASE, 11'd0, xmem address of activation word 0.
- ADDR_W, 11, SRAM address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a layer when idle.
- dbi_cfg  in  1  DBI enable, copied to inst[47].
- ofifo_valid  in  1  from core; OFIFO has a word.
- inst  out  48  registered core instruction word.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the final write completes.
- kij_idx  out  4  current kij (debug/visibility).

Behaviour:
- Inst field map:
  - [1:0] {execute, load}; [2] l0_wr; [3] l0_rd; [6] ofifo_rd.
  - [17:7] xmem A, [18] xmem WEN, [19] xmem CEN.
  - [30:20] pmem A, [31] pmem WEN, [32] pmem CEN.
  - [33] acc.
  - [44:34] fmem A, [45] fmem WEN, [46] fmem CEN.
  - [47] dbi_en.
  - All CEN/WEN are active-low.
  - Unused bits [5:4] are always 0.
- Reset and IDLE word:
  - `inst` = 48'h6001_800C_0000 (all CEN/WEN high, everything else 0); busy=0, done=0, kij_idx=0.
  - In every state, inst[47] = dbi_cfg registered.
- Reset mid-operation: next cycle is IDLE word, all counters zeroed, no done pulse.
- start while busy: ignored.
- FSM: IDLE -> W_RD -> W_LD -> A_RD -> A_EX -> DRAIN -> (kij<len_kij-1 ? W_RD with kij+1 : ACC) -> FIN -> IDLE.
- SRAM read latency is 1 cycle, so each *_RD state runs N+1 cycles with counter t=0..N:
  - xmem CEN=0, WEN=1, A=base+t for t<N;
  - l0_wr=1 for t>=1.
- W_RD (N=row):
  - base = W_BASE + kij*row.
- W_LD: row cycles with l0_rd=1 and inst[0]=1, then 1 idle cycle.
- A_RD (N=len_nij):
  - base = A_BASE.
- A_EX: len_nij cycles with l0_rd=1 and inst[1]=1.
- DRAIN:
  - Each cycle with ofifo_valid=1 and cnt<len_nij: ofifo_rd=1 and, in the same cycle, pmem CEN=0, WEN=0, A = kij*len_nij + cnt; then cnt++.
  - ofifo_valid=0: hold, all strobes inactive.
  - Exit when cnt==len_nij. There is no timeout.
- ACC, per onij o=0..len_onij-1, len_kij+2 cycles, c=0..len_kij+1:
  - c<len_kij: pmem read, A = k*len_nij + (o/OW + k/KW)*IW + (o%OW + k%KW) with k=c.
  - acc=1 for 1<=c<=len_kij.
  - c=len_kij+1: acc=0; fmem CEN=0, WEN=0, A=o.
  - acc therefore drops for at least 1 cycle between groups; SFP zeroing on the first acc of a group is the corelet's job.
- FIN: one cycle, done=1, busy falls the next cycle.
- Arithmetic and outputs:
  - All address arithmetic is unsigned and truncated to ADDR_W; parameters must keep results < 2^ADDR_W.
  - Division and modulo are by parameter constants; use counters (o_row/o_col, k_row/k_col) rather than dividers.
  - All outputs are registered; no combinational path from ofifo_valid to inst.

Decomposition:
- Package core_seq_pkg holds:
  - the state enum;
  - bit-position localparams for every inst field;
  - IDLE_INST constant;
  - `function nij_addr(o_row, o_col, k_row, k_col)`.
- One sub-module, seq_counter: loadable up-counter with terminal-count flag, instantiated for t/cnt, kij, o and c.

Test Plan:
- Reset then idle 5 cycles -> inst==48'h6001_800C_0000, busy=0, done=0; start asserted with reset high -> still idle.
- start with kij=0, W_BASE=64 -> W_RD:
  - xmem A = 64..71 with CEN=0 on cycles 1..8 after start;
  - l0_wr high cycles 2..9;
  - then 8 cycles with inst[3]=inst[0]=1.
- DRAIN with ofifo_valid toggling 1,0,1,… -> exactly 36 pmem writes, A = kij*36 + 0..35, each coincident with ofifo_rd; no strobe on valid=0 cycles.
- ACC, onij o=5, k=4 -> pmem A = 4*36 + (1+1)*6 + (1+1) = 158.
  - fmem write A=5 at c=10 with acc=0;
  - acc high exactly 9 cycles per group.
- Full layer with ofifo_valid tied 1:
  - exactly 16 fmem writes (A 0..15);
  - done a single pulse;
  - cycle count = 9*(9+9+37+36+36) + 16*11 + 1 (±FSM transition cycles as documented in RTL header).
- reset asserted during A_EX at kij=3 -> next cycle IDLE word, kij_idx=0; new start restarts at W_RD with kij=0.
